data_bus_slave: RTL and testbench



---
 rtl/bus_map_pkg.sv | 45 ++++
 rtl/data_bus_slave_if.sv | 26 ++
 rtl/bus_timer.sv | 70 +++++++
 rtl/data_bus_slave.sv | 100 ++++++++++
 tb/tb_data_bus_slave.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_map_pkg.sv
// -----------------------------------------------------------------------------
// bus_map_pkg
// Address map of the CPU data-bus slave: I/O register offsets relative to the
// I/O window base, the default read value for unmapped addresses, the decode
// result enum and the address decode helper shared by the slave.
// -----------------------------------------------------------------------------
package bus_map_pkg;

  // Register offsets inside the I/O window (bytes, word aligned).
  localparam logic [31:0] OFF_IO_OUT  = 32'h0000_0000;
  localparam logic [31:0] OFF_TMR_CNT = 32'h0000_0004;
  localparam logic [31:0] OFF_TMR_CMP = 32'h0000_0008;
  localparam logic [31:0] OFF_STATUS  = 32'h0000_000C;

  // Read value for addresses that hit nothing.
  localparam logic [31:0] UNMAPPED_VAL = 32'h0000_1DAA;

  // The RAM window always spans byte addresses 0x0000_0000 .. 0x0000_0FFF.
  localparam logic [31:0] RAM_WIN_SIZE = 32'h0000_1000;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_IO,
    SEL_CNT,
    SEL_CMP,
    SEL_STAT,
    SEL_NONE
  } sel_e;

  // Classify a byte address; ADDR[1:0] never takes part in the decision.
  function automatic sel_e decode_addr(input logic [31:0] addr,
                                       input logic [31:0] io_base);
    logic [31:0] word_addr;
    sel_e        sel;
    word_addr = {addr[31:2], 2'b00};
    sel       = SEL_NONE;
    if (word_addr < RAM_WIN_SIZE)                   sel = SEL_RAM;
    else if (word_addr == io_base + OFF_IO_OUT)     sel = SEL_IO;
    else if (word_addr == io_base + OFF_TMR_CNT)    sel = SEL_CNT;
    else if (word_addr == io_base + OFF_TMR_CMP)    sel = SEL_CMP;
    else if (word_addr == io_base + OFF_STATUS)     sel = SEL_STAT;
    return sel;
  endfunction

endpackage

// File: rtl/data_bus_slave_if.sv
// -----------------------------------------------------------------------------
// data_bus_slave_if
// CPU data-bus signals between the CPU (master) and the memory/I/O slave.
//   ADDR            master -> slave  byte address
//   Data_BUS_WRITE  master -> slave  write data
//   CS              master -> slave  bus cycle valid
//   WR_RD           master -> slave  1 = write, 0 = read
//   Data_BUS_READ   slave  -> master registered read data
// -----------------------------------------------------------------------------
interface data_bus_slave_if;
  logic [31:0] ADDR;
  logic [31:0] Data_BUS_WRITE;
  logic        CS;
  logic        WR_RD;
  logic [31:0] Data_BUS_READ;

  modport master (
    output ADDR, Data_BUS_WRITE, CS, WR_RD,
    input  Data_BUS_READ
  );

  modport slave (
    input  ADDR, Data_BUS_WRITE, CS, WR_RD,
    output Data_BUS_READ
  );
endinterface

// File: rtl/bus_timer.sv
// -----------------------------------------------------------------------------
// bus_timer
// Free-running compare timer with a sticky match flag.
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   cnt_we_i  in   load the counter with wdata_i this cycle
//   cmp_we_i  in   load the compare register with wdata_i this cycle
//   stat_we_i in   STATUS write; wdata_i[0]=1 clears the flag
//   wdata_i   in   CPU write data
//   cnt_o     out  current counter value
//   cmp_o     out  current compare value
//   flag_o    out  sticky match flag
// -----------------------------------------------------------------------------
module bus_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cnt_we_i,
  input  logic        cmp_we_i,
  input  logic        stat_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] cnt_o,
  output logic [31:0] cmp_o,
  output logic        flag_o
);

  logic [31:0] cnt_q, cnt_d;
  logic [31:0] cmp_q, cmp_d;
  logic        flag_q, flag_d;
  logic        match;

  // Compare uses the registered CMP, so a CMP write only matters next cycle.
  assign match = (cnt_q == cmp_q);

  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    cnt_d  = cnt_q + 32'd1;
    cmp_d  = cmp_q;
    flag_d = flag_q;

    if (match)    cnt_d = '0;
    // A CPU load beats both the increment and the match reload.
    if (cnt_we_i) cnt_d = wdata_i;

    if (cmp_we_i) cmp_d = wdata_i;

    if (stat_we_i && wdata_i[0]) flag_d = 1'b0;
    // Set is evaluated last so a match wins over a same-cycle clear.
    if (match)                   flag_d = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      cmp_q  <= '1;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      cmp_q  <= cmp_d;
      flag_q <= flag_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign cmp_o  = cmp_q;
  assign flag_o = flag_q;

endmodule

// File: rtl/data_bus_slave.sv
// -----------------------------------------------------------------------------
// data_bus_slave
// Memory and memory-mapped I/O slave on the CPU data bus. Decodes the bus,
// hosts a 2^RAM_AW word data RAM, an output port register and a compare timer,
// and returns registered read data one clock after a read request.
//   CLK     in   system clock, rising edge
//   Rst     in   asynchronous active-low reset
//   bus     if   data_bus_slave_if.slave (ADDR, Data_BUS_WRITE, CS, WR_RD,
//                Data_BUS_READ)
//   IO_OUT  out  output port register
//   IRQ     out  timer match flag
// -----------------------------------------------------------------------------
module data_bus_slave #(
  parameter int          RAM_AW       = 10,
  parameter logic [31:0] IO_BASE      = 32'h0000_1000,
  parameter logic [31:0] UNMAPPED_VAL = bus_map_pkg::UNMAPPED_VAL
) (
  input  logic              CLK,
  input  logic              Rst,
  data_bus_slave_if.slave   bus,
  output logic [31:0]       IO_OUT,
  output logic              IRQ
);

  import bus_map_pkg::*;

  sel_e              sel;
  logic              wr_req;
  logic              rd_req;
  logic [RAM_AW-1:0] ram_idx;
  logic [31:0]       rd_mux;

  logic [31:0]       ram_q [2**RAM_AW];
  logic [31:0]       io_out_q, io_out_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [31:0]       tmr_cnt;
  logic [31:0]       tmr_cmp;
  logic              tmr_flag;

  assign sel     = decode_addr(bus.ADDR, IO_BASE);
  assign wr_req  = bus.CS &  bus.WR_RD;
  assign rd_req  = bus.CS & ~bus.WR_RD;
  assign ram_idx = bus.ADDR[RAM_AW+1:2];

  // NOTE: the RAM is deliberately left out of reset so it maps onto a plain
  // memory macro; its write happens only on the clock edge, which is also why
  // a reset pulse never corrupts it.
  always_ff @(posedge CLK) begin
    if (wr_req && sel == SEL_RAM) ram_q[ram_idx] <= bus.Data_BUS_WRITE;
  end

  bus_timer u_timer (
    .clk       (CLK),
    .rst_n     (Rst),
    .cnt_we_i  (wr_req && sel == SEL_CNT),
    .cmp_we_i  (wr_req && sel == SEL_CMP),
    .stat_we_i (wr_req && sel == SEL_STAT),
    .wdata_i   (bus.Data_BUS_WRITE),
    .cnt_o     (tmr_cnt),
    .cmp_o     (tmr_cmp),
    .flag_o    (tmr_flag)
  );

  // Read mux sees pre-edge register values, so TMR_CNT reads its cycle-N value.
  always_comb begin
    rd_mux = UNMAPPED_VAL;
    case (sel)
      SEL_RAM:  rd_mux = ram_q[ram_idx];
      SEL_IO:   rd_mux = io_out_q;
      SEL_CNT:  rd_mux = tmr_cnt;
      SEL_CMP:  rd_mux = tmr_cmp;
      SEL_STAT: rd_mux = {31'b0, tmr_flag};
      default:  rd_mux = UNMAPPED_VAL;
    endcase
  end

  // Read data only moves on a read; writes and idle cycles hold it.
  always_comb begin
    io_out_d = io_out_q;
    rdata_d  = rdata_q;
    if (wr_req && sel == SEL_IO) io_out_d = bus.Data_BUS_WRITE;
    if (rd_req)                  rdata_d  = rd_mux;
  end

  always_ff @(posedge CLK or negedge Rst) begin
    if (!Rst) begin
      io_out_q <= '0;
      rdata_q  <= '0;
    end else begin
      io_out_q <= io_out_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.Data_BUS_READ = rdata_q;
  assign IO_OUT            = io_out_q;
  assign IRQ               = tmr_flag;

endmodule

// File: tb/tb_data_bus_slave.sv
// -----------------------------------------------------------------------------
// tb_data_bus_slave
// Self-checking bench for data_bus_slave: directed scenarios followed by
// randomized bus traffic, all compared against a behavioural model of the
// memory map and timer rules kept in this file.
// -----------------------------------------------------------------------------
module tb_data_bus_slave;

  localparam logic [31:0] IO_BASE  = 32'h0000_1000;
  localparam logic [31:0] A_IO     = IO_BASE + 32'h0;
  localparam logic [31:0] A_CNT    = IO_BASE + 32'h4;
  localparam logic [31:0] A_CMP    = IO_BASE + 32'h8;
  localparam logic [31:0] A_STAT   = IO_BASE + 32'hC;
  localparam logic [31:0] UNMAPPED = 32'h0000_1DAA;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] io_out;
  logic        irq;

  data_bus_slave_if bus ();

  data_bus_slave #(
    .RAM_AW       (10),
    .IO_BASE      (IO_BASE),
    .UNMAPPED_VAL (UNMAPPED)
  ) dut (
    .CLK    (clk),
    .Rst    (rst_n),
    .bus    (bus),
    .IO_OUT (io_out),
    .IRQ    (irq)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model ---
  logic [31:0] m_cnt, m_cmp, m_io, m_rd;
  logic        m_flag;
  bit          m_rd_known;
  logic [31:0] m_ram [int];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_cnt      = 32'h0;
    m_cmp      = 32'hFFFF_FFFF;
    m_io       = 32'h0;
    m_rd       = 32'h0;
    m_rd_known = 1'b1;
    m_flag     = 1'b0;
  endtask

  // One bus cycle. Called at a falling edge: drives the request, advances the
  // model by one clock using the memory-map and timer rules, then checks all
  // outputs just after the rising edge. Returns at the next falling edge.
  task automatic bus_cycle(input bit cs, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata);
    logic [31:0] wa;
    logic [31:0] rv;
    bit          rv_known;
    bit          is_match;
    logic [31:0] nxt_cnt;
    logic        nxt_flag;

    bus.CS             = cs;
    bus.WR_RD          = wr;
    bus.ADDR           = addr;
    bus.Data_BUS_WRITE = wdata;

    wa       = addr & ~32'h3;
    rv_known = 1'b1;
    if (wa < 32'h1000) begin
      if (m_ram.exists(int'(wa >> 2))) rv = m_ram[int'(wa >> 2)];
      else begin
        rv       = 32'h0;
        rv_known = 1'b0;
      end
    end
    else if (wa == A_IO)   rv = m_io;
    else if (wa == A_CNT)  rv = m_cnt;
    else if (wa == A_CMP)  rv = m_cmp;
    else if (wa == A_STAT) rv = {31'b0, m_flag};
    else                   rv = UNMAPPED;

    // Timer rules: count up, reload to 0 on a match, CPU load overrides both;
    // a match sets the flag even when a write-1-clear arrives with it.
    is_match = (m_cnt == m_cmp);
    nxt_cnt  = is_match ? 32'h0 : m_cnt + 32'h1;
    nxt_flag = m_flag;
    if (cs && wr && wa == A_CNT)              nxt_cnt  = wdata;
    if (cs && wr && wa == A_STAT && wdata[0]) nxt_flag = 1'b0;
    if (is_match)                             nxt_flag = 1'b1;
    m_cnt  = nxt_cnt;
    m_flag = nxt_flag;

    if (cs && wr) begin
      if (wa < 32'h1000)    m_ram[int'(wa >> 2)] = wdata;
      else if (wa == A_IO)  m_io  = wdata;
      else if (wa == A_CMP) m_cmp = wdata;
    end
    if (cs && !wr) begin
      m_rd       = rv;
      m_rd_known = rv_known;
    end

    @(posedge clk);
    #1;
    check("io_out", io_out, m_io);
    check("irq", {31'b0, irq}, {31'b0, m_flag});
    if (m_rd_known) check("rdata", bus.Data_BUS_READ, m_rd);
    else check("rdata_nox", {31'b0, $isunknown(bus.Data_BUS_READ)}, 32'h0);
    @(negedge clk);
  endtask

  task automatic idle();
    bus_cycle(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Idle until the model predicts a match this cycle (bounded).
  task automatic idle_to_match();
    for (int k = 0; k < 64 && m_cnt != m_cmp; k++) idle();
  endtask

  // ------------------------------------------------------------- stimulus ---
  initial begin
    bus.CS             = 1'b0;
    bus.WR_RD          = 1'b0;
    bus.ADDR           = 32'h0;
    bus.Data_BUS_WRITE = 32'h0;

    // Reset, checked asynchronously before the first rising edge.
    #1 rst_n = 1'b0;
    #2;
    check("rst_io_out", io_out, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_rdata", bus.Data_BUS_READ, 32'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Unmapped read.
    bus_cycle(1'b1, 1'b0, 32'h0000_2000, 32'h0);
    check("unmapped_rd", bus.Data_BUS_READ, 32'h0000_1DAA);
    check("io_out_after_rst", io_out, 32'h0);

    // RAM write then read of the same word with low address bits set.
    bus_cycle(1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    bus_cycle(1'b1, 1'b0, 32'h0000_0013, 32'h0);
    check("ram_rd_after_wr", bus.Data_BUS_READ, 32'hDEAD_BEEF);

    // Output port; the write and an idle cycle leave read data alone.
    bus_cycle(1'b1, 1'b1, A_IO, 32'h0000_00A5);
    check("io_out_wr", io_out, 32'h0000_00A5);
    idle();
    check("idle_hold", bus.Data_BUS_READ, 32'hDEAD_BEEF);

    // Unwritten RAM at the top of the window.
    bus_cycle(1'b1, 1'b0, 32'h0000_0FFC, 32'h0);

    // Compare timer: CMP=5, CNT=0, IRQ rises six edges after the load.
    bus_cycle(1'b1, 1'b1, A_CMP, 32'd5);
    bus_cycle(1'b1, 1'b1, A_CNT, 32'd0);
    for (int k = 1; k <= 6; k++) begin
      idle();
      check($sformatf("irq_rise_%0d", k), {31'b0, irq}, (k == 6) ? 32'h1 : 32'h0);
    end
    bus_cycle(1'b1, 1'b0, A_CNT, 32'h0);
    check("cnt_after_match", bus.Data_BUS_READ, 32'h0);
    bus_cycle(1'b1, 1'b1, A_STAT, 32'h1);
    check("w1c_clears", {31'b0, irq}, 32'h0);
    bus_cycle(1'b1, 1'b0, A_STAT, 32'h0);
    check("status_rd", bus.Data_BUS_READ, 32'h0);

    // Write-1-clear coinciding with a match: set wins.
    idle_to_match();
    bus_cycle(1'b1, 1'b1, A_STAT, 32'h1);
    check("match_beats_clear", {31'b0, irq}, 32'h1);

    // Counter load coinciding with a match: load wins.
    idle_to_match();
    bus_cycle(1'b1, 1'b1, A_CNT, 32'd100);
    bus_cycle(1'b1, 1'b0, A_CNT, 32'h0);
    check("load_beats_reload", bus.Data_BUS_READ, 32'd100);

    // Natural overflow with CMP=5 does not set the flag.
    bus_cycle(1'b1, 1'b1, A_STAT, 32'h1);
    bus_cycle(1'b1, 1'b1, A_CNT, 32'hFFFF_FFFE);
    for (int k = 0; k < 4; k++) idle();
    check("overflow_no_flag", {31'b0, irq}, 32'h0);

    // CMP=all-ones: the terminal count does match.
    bus_cycle(1'b1, 1'b1, A_CMP, 32'hFFFF_FFFF);
    bus_cycle(1'b1, 1'b1, A_CNT, 32'hFFFF_FFFD);
    for (int k = 0; k < 3; k++) idle();
    check("max_cmp_flag", {31'b0, irq}, 32'h1);
    bus_cycle(1'b1, 1'b0, A_CNT, 32'h0);
    check("max_cmp_reload", bus.Data_BUS_READ, 32'h0);

    // Reset in the middle of a write cycle with IO_OUT=0x55 and flag=1.
    bus_cycle(1'b1, 1'b1, A_IO, 32'h55);
    bus.CS             = 1'b1;
    bus.WR_RD          = 1'b1;
    bus.ADDR           = A_IO;
    bus.Data_BUS_WRITE = 32'h77;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_io_out", io_out, 32'h0);
    check("async_rst_irq", {31'b0, irq}, 32'h0);
    check("async_rst_rdata", bus.Data_BUS_READ, 32'h0);
    model_reset();
    bus.CS = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus_cycle(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    check("ram_survives_rst", bus.Data_BUS_READ, 32'hDEAD_BEEF);
    check("io_out_not_committed", io_out, 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] addr;
      logic [31:0] wdata;
      int          pick;
      pick  = $urandom_range(0, 7);
      wdata = $urandom;
      case (pick)
        0, 1, 2: addr = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
        3:       addr = A_IO  | $urandom_range(0, 3);
        4: begin
          addr  = A_CNT;
          wdata = $urandom_range(0, 20);
        end
        5: begin
          addr  = A_CMP;
          wdata = $urandom_range(0, 20);
        end
        6:       addr = A_STAT;
        default: addr = ($urandom_range(0, 1) == 0) ? 32'h0000_2000 : IO_BASE + 32'h10;
      endcase
      bus_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, addr, wdata);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
